// File: rtl/fsm_cpu_periferico_link.sv
// CPU-to-peripheral word link: a CPU-side FSM and a peripheral-side FSM on one clock,
// exchanging 2-bit words over a four-phase send/ack handshake, with an accepted-word counter.
module fsm_cpu_periferico_link (
  input  logic       clk1,
  input  logic       rst1,
  input  logic       cpuReq,
  input  logic [1:0] cpuData,
  output logic       cpuBusy,
  output logic       send,
  output logic [1:0] dataInput,
  output logic       ack,
  output logic [1:0] rxData,
  output logic       rxValid,
  output logic [7:0] rxCount
);

  typedef enum logic [1:0] {
    CPU_IDLE         = 2'b00,
    CPU_SEND         = 2'b01,
    CPU_WAIT_ACK_LOW = 2'b10
  } cpuState_t;

  typedef enum logic {
    PER_WAIT_SEND = 1'b0,
    PER_ACKED     = 1'b1
  } perState_t;

  cpuState_t  r_cpuState, w_cpuNext;
  perState_t  r_perState, w_perNext;
  logic       r_send, w_sendNext;
  logic [1:0] r_dataInput, w_dataNext;
  logic       r_ack, w_ackNext;
  logic [1:0] r_rxData, w_rxDataNext;
  logic       r_rxValid, w_rxValidNext;
  logic [7:0] r_rxCount, w_rxCountNext;

  always_ff @(posedge clk1 or negedge rst1) begin
    if (!rst1) begin
      r_cpuState  <= CPU_IDLE;
      r_send      <= 1'b0;
      r_dataInput <= 2'b00;
    end else begin
      r_cpuState  <= w_cpuNext;
      r_send      <= w_sendNext;
      r_dataInput <= w_dataNext;
    end
  end

  // The cycle in which ack is seen low again counts as reaching IDLE, so a held
  // request re-launches right there and keeps the 4-cycle word rate.
  always_comb begin
    w_cpuNext  = r_cpuState;
    w_sendNext = r_send;
    w_dataNext = r_dataInput;
    case (r_cpuState)
      CPU_IDLE: begin
        w_sendNext = 1'b0;
        if (cpuReq) begin
          w_dataNext = cpuData;
          w_sendNext = 1'b1;
          w_cpuNext  = CPU_SEND;
        end
      end
      CPU_SEND: begin
        w_sendNext = 1'b1;
        if (r_ack) begin
          w_sendNext = 1'b0;
          w_cpuNext  = CPU_WAIT_ACK_LOW;
        end
      end
      CPU_WAIT_ACK_LOW: begin
        w_sendNext = 1'b0;
        if (!r_ack) begin
          if (cpuReq) begin
            w_dataNext = cpuData;
            w_sendNext = 1'b1;
            w_cpuNext  = CPU_SEND;
          end else begin
            w_cpuNext  = CPU_IDLE;
          end
        end
      end
      default: begin
        w_sendNext = 1'b0;
        w_cpuNext  = CPU_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk1 or negedge rst1) begin
    if (!rst1) begin
      r_perState <= PER_WAIT_SEND;
      r_ack      <= 1'b0;
      r_rxData   <= 2'b00;
      r_rxValid  <= 1'b0;
      r_rxCount  <= 8'd0;
    end else begin
      r_perState <= w_perNext;
      r_ack      <= w_ackNext;
      r_rxData   <= w_rxDataNext;
      r_rxValid  <= w_rxValidNext;
      r_rxCount  <= w_rxCountNext;
    end
  end

  // Capture happens only on the WAIT_SEND -> ACKED step, so a word is never taken twice.
  always_comb begin
    w_perNext     = r_perState;
    w_ackNext     = r_ack;
    w_rxDataNext  = r_rxData;
    w_rxValidNext = 1'b0;
    w_rxCountNext = r_rxCount;
    case (r_perState)
      PER_WAIT_SEND: begin
        w_ackNext = 1'b0;
        if (r_send) begin
          w_rxDataNext  = r_dataInput;
          w_ackNext     = 1'b1;
          w_rxValidNext = 1'b1;
          w_rxCountNext = r_rxCount + 8'd1;
          w_perNext     = PER_ACKED;
        end
      end
      PER_ACKED: begin
        w_ackNext = 1'b1;
        if (!r_send) begin
          w_ackNext = 1'b0;
          w_perNext = PER_WAIT_SEND;
        end
      end
      default: begin
        w_ackNext = 1'b0;
        w_perNext = PER_WAIT_SEND;
      end
    endcase
  end

  assign cpuBusy   = (r_cpuState != CPU_IDLE);
  assign send      = r_send;
  assign dataInput = r_dataInput;
  assign ack       = r_ack;
  assign rxData    = r_rxData;
  assign rxValid   = r_rxValid;
  assign rxCount   = r_rxCount;

endmodule

// File: tb/tb_fsm_cpu_periferico_link.sv
// Directed bench for fsm_cpu_periferico_link: reset, single and back-to-back transfers,
// ignored requests, counter wrap and reset in the middle of a handshake.
module tb_fsm_cpu_periferico_link;

  logic       clk1;
  logic       rst1;
  logic       cpuReq;
  logic [1:0] cpuData;
  logic       cpuBusy;
  logic       send;
  logic [1:0] dataInput;
  logic       ack;
  logic [1:0] rxData;
  logic       rxValid;
  logic [7:0] rxCount;

  int passCount;
  int failCount;
  int checkCount;

  fsm_cpu_periferico_link dut (
    .clk1      (clk1),
    .rst1      (rst1),
    .cpuReq    (cpuReq),
    .cpuData   (cpuData),
    .cpuBusy   (cpuBusy),
    .send      (send),
    .dataInput (dataInput),
    .ack       (ack),
    .rxData    (rxData),
    .rxValid   (rxValid),
    .rxCount   (rxCount)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) begin
      passCount++;
    end else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One complete transfer: request sampled at the next edge, CPU back in IDLE after 5 edges.
  task automatic applyStimulus(input logic [1:0] word);
    cpuReq  = 1'b1;
    cpuData = word;
    tick();
    cpuReq = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    passCount  = 0;
    failCount  = 0;
    checkCount = 0;
    cpuReq     = 1'b0;
    cpuData    = 2'b00;
    rst1       = 1'b0;

    // Reset held for 5 cycles with cpuReq toggling
    for (int i = 0; i < 5; i++) begin
      cpuReq  = i[0];
      cpuData = 2'b11;
      tick();
    end
    checkOutput("rst_send", send, 0);
    checkOutput("rst_ack", ack, 0);
    checkOutput("rst_busy", cpuBusy, 0);
    checkOutput("rst_dataInput", dataInput, 0);
    checkOutput("rst_rxData", rxData, 0);
    checkOutput("rst_rxValid", rxValid, 0);
    checkOutput("rst_rxCount", rxCount, 0);
    cpuReq = 1'b0;
    rst1   = 1'b1;
    repeat (2) tick();
    checkOutput("post_rst_busy", cpuBusy, 0);
    checkOutput("post_rst_send", send, 0);
    checkOutput("post_rst_rxCount", rxCount, 0);

    // Single transfer of 2'b11
    cpuReq  = 1'b1;
    cpuData = 2'b11;
    tick();
    cpuReq = 1'b0;
    checkOutput("k_send", send, 1);
    checkOutput("k_dataInput", dataInput, 2'b11);
    checkOutput("k_busy", cpuBusy, 1);
    checkOutput("k_ack", ack, 0);
    tick();
    checkOutput("k1_ack", ack, 1);
    checkOutput("k1_rxValid", rxValid, 1);
    checkOutput("k1_rxData", rxData, 2'b11);
    checkOutput("k1_rxCount", rxCount, 1);
    checkOutput("k1_busy", cpuBusy, 1);
    tick();
    checkOutput("k2_send", send, 0);
    checkOutput("k2_rxValid", rxValid, 0);
    checkOutput("k2_busy", cpuBusy, 1);
    tick();
    checkOutput("k3_ack", ack, 0);
    checkOutput("k3_busy", cpuBusy, 1);
    tick();
    checkOutput("k4_busy", cpuBusy, 0);
    tick();
    checkOutput("k5_busy", cpuBusy, 0);
    checkOutput("k5_rxCount", rxCount, 1);
    checkOutput("k5_dataInput_kept", dataInput, 2'b11);

    // Back-to-back with cpuReq held high
    cpuReq  = 1'b1;
    cpuData = 2'b11;
    tick();
    checkOutput("b2b_k_send", send, 1);
    tick();
    checkOutput("b2b_k1_rxValid", rxValid, 1);
    checkOutput("b2b_k1_rxData", rxData, 2'b11);
    checkOutput("b2b_k1_rxCount", rxCount, 2);
    cpuData = 2'b10;
    tick();
    checkOutput("b2b_k2_dataInput", dataInput, 2'b11);
    checkOutput("b2b_k2_rxValid", rxValid, 0);
    tick();
    checkOutput("b2b_k3_rxValid", rxValid, 0);
    checkOutput("b2b_k3_ack", ack, 0);
    tick();
    checkOutput("b2b_k4_send", send, 1);
    checkOutput("b2b_k4_dataInput", dataInput, 2'b10);
    checkOutput("b2b_k4_busy", cpuBusy, 1);
    checkOutput("b2b_k4_rxValid", rxValid, 0);
    cpuReq  = 1'b0;
    cpuData = 2'b01;
    tick();
    checkOutput("b2b_k5_rxValid", rxValid, 1);
    checkOutput("b2b_k5_rxData", rxData, 2'b10);
    checkOutput("b2b_k5_rxCount", rxCount, 3);
    checkOutput("b2b_k5_dataInput_held", dataInput, 2'b10);
    repeat (3) tick();
    checkOutput("b2b_idle_busy", cpuBusy, 0);

    // Request pulsed while busy is ignored
    cpuReq  = 1'b1;
    cpuData = 2'b01;
    tick();
    cpuReq = 1'b0;
    tick();
    checkOutput("ign_rxCount_first", rxCount, 4);
    cpuReq  = 1'b1;
    cpuData = 2'b10;
    tick();
    cpuReq = 1'b0;
    repeat (5) tick();
    checkOutput("ign_rxCount", rxCount, 4);
    checkOutput("ign_send", send, 0);
    checkOutput("ign_dataInput", dataInput, 2'b01);
    checkOutput("ign_busy", cpuBusy, 0);

    // Counter wrap from a fresh reset
    rst1 = 1'b0;
    tick();
    rst1 = 1'b1;
    tick();
    checkOutput("wrap_start", rxCount, 0);
    for (int i = 0; i < 255; i++) applyStimulus(i[1:0]);
    checkOutput("wrap_255", rxCount, 255);
    applyStimulus(2'b10);
    checkOutput("wrap_256", rxCount, 0);
    checkOutput("wrap_256_rxData", rxData, 2'b10);
    applyStimulus(2'b01);
    checkOutput("wrap_257", rxCount, 1);
    checkOutput("wrap_257_rxData", rxData, 2'b01);

    // Reset asserted while ack is high
    cpuReq  = 1'b1;
    cpuData = 2'b11;
    tick();
    cpuReq = 1'b0;
    tick();
    checkOutput("mid_ack_before", ack, 1);
    checkOutput("mid_rxCount_before", rxCount, 2);
    #2;
    rst1 = 1'b0;
    #1;
    checkOutput("mid_send", send, 0);
    checkOutput("mid_ack", ack, 0);
    checkOutput("mid_rxCount", rxCount, 0);
    checkOutput("mid_busy", cpuBusy, 0);
    tick();
    rst1 = 1'b1;
    tick();
    checkOutput("mid_no_retx", send, 0);
    applyStimulus(2'b10);
    checkOutput("mid_after_rxCount", rxCount, 1);
    checkOutput("mid_after_rxData", rxData, 2'b10);
    checkOutput("mid_after_busy", cpuBusy, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
